smooth_col_feeder: RTL and testbench
====================================

# smooth_col_feeder

Raster-to-column front end for the 5-tap vertical smoothing stage. It accepts one 8-bit grey pixel per valid cycle in raster order and keeps the previous four image rows in line memories. For every accepted pixel it emits a registered 40-bit vertical column of five pixels, packed top to bottom, for the downstream column-pipelined Gaussian filter. It also emits the pixel coordinates and a frame-end pulse so downstream stages can align borders.

## Interface
- WIDTH, 12'd640: pixels per line; legal range 5..4095.
- HEIGHT, 12'd480: lines per frame; legal range 5..4095.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pixel  in  8  incoming pixel, raster order.
- i_valid  in  1  i_pixel is accepted this cycle; no backpressure exists.
- i_sof  in  1  start of frame; qualified by i_valid, marks pixel (0,0).
- o_col  out  40  column; [39:32]=row y-4, [31:24]=y-3, [23:16]=y-2, [15:8]=y-1, [7:0]=row y (current pixel).
- o_valid  out  1  o_col, o_x and o_y are valid this cycle.
- o_x  out  12  column index x of the current pixel.
- o_y  out  12  row index y of the current pixel (bottom tap).
- o_frame_end  out  1  one-cycle pulse coincident with the output for pixel (WIDTH-1,HEIGHT-1).
- o_sync_err  out  1  one-cycle pulse when i_sof arrives while the position counters are not at (0,0).

## Operation
- Storage: four line memories L1..L4, each WIDTH x 8. L1 holds row y-1 and L4 holds row y-4.
- Accepted pixel at column x (i_valid=1):
  - Read L1[x]..L4[x] before any write.
  - Register o_col = {L4[x],L3[x],L2[x],L1[x],i_pixel}.
  - Write L1[x]<=i_pixel, L2[x]<=old L1[x], L3[x]<=old L2[x], L4[x]<=old L3[x].
- Position counters x_cnt and y_cnt advance only on accepted pixels.
  - x wraps WIDTH-1 -> 0 and then increments y.
  - y wraps HEIGHT-1 -> 0 after the last pixel of the frame.
  - o_x and o_y are the pre-increment values of the accepted pixel.
- i_sof with i_valid forces the accepted pixel to (0,0); the counters then continue from there.
  - If the counters were not already at (0,0), assert o_sync_err for the same output cycle.
  - i_sof without i_valid is ignored.
- Output qualification: o_valid = accepted pixel AND y >= 4, unless LINEBUF_ZERO_PAD_EN is defined.
- Idle (i_valid=0): no memory write, no counter change. Next cycle o_valid=0 and o_frame_end=0; o_col, o_x and o_y hold their values.
- Line memories are not cleared by reset. All correctness for y<4 comes from the qualification or masking rules above, never from memory contents.

## Timing
- Latency: exactly 1 cycle from the accepting i_valid edge to the o_valid/o_col edge.
- Throughput: 1 pixel per cycle, sustained with no bubbles; arbitrary gaps between pixels are allowed.
- Reset values: o_col=0, o_valid=0, o_x=0, o_y=0, o_frame_end=0, o_sync_err=0, x_cnt=0, y_cnt=0.
- Reset asserted mid-frame: all outputs and counters clear immediately (asynchronous). The first accepted pixel after reset is treated as (0,0).
- Simultaneous events:
  - i_sof on the last pixel of a frame: counters are at (WIDTH-1,HEIGHT-1), not (0,0), so o_sync_err=1. The pixel is resynced to (0,0) and o_frame_end stays 0.
  - The line memories use read-during-write of the same address, and the old data must be returned.
- Counter and coordinate width: 12 bits. No counter may reach WIDTH or HEIGHT.

## Configuration
- LINEBUF_ZERO_PAD_EN defined:
  - o_valid is asserted for every accepted pixel, including rows 0..3.
  - Taps that reference rows above row 0 are forced to 8'h00. For y=k<4, the top 4-k bytes of o_col are zero.
  - Output count per frame is WIDTH*HEIGHT.
- LINEBUF_ZERO_PAD_EN not defined:
  - o_valid is suppressed for y<4; no masking logic is built.
  - Output count per frame is WIDTH*(HEIGHT-4).
- o_frame_end behaves identically in both builds.

## Test plan
- Bench setup: WIDTH=8, HEIGHT=6, pixel value = 16*y+x, continuous i_valid, i_sof on the first pixel.
- Full frame, no macro -> first o_valid is at output (0,4) with o_col=40'h0010203040. At (3,4), o_col=40'h0313233343. At (7,5), o_col=40'h1727374757 with o_frame_end=1. Exactly 16 valid outputs.
- Same frame with LINEBUF_ZERO_PAD_EN defined -> 48 valid outputs. At (2,1), o_col=40'h0000000212. At (0,0), o_col=40'h0000000000.
- Gapped input: i_valid toggled 1/0 every cycle -> identical o_col/o_x/o_y sequence to the continuous run. o_valid never asserts on cycles following a gap.
- Stray i_sof at pixel (5,2) -> o_sync_err pulses once and o_x=0, o_y=0 on that output. Subsequent outputs continue from (1,0).
- i_rst_n pulsed low at (4,3) -> all outputs read 0 during reset. The next frame (first pixel sent without i_sof) produces first valid output (0,4), and o_sync_err stays 0.

Source files
------------

// File: rtl/smooth_col_feeder.sv
// smooth_col_feeder: raster-to-column front end for a 5-tap vertical smoother.
// Accepts one 8-bit pixel per valid cycle in raster order. Four line memories
// hold the previous four rows. Each accepted pixel produces a registered 40-bit
// column {y-4, y-3, y-2, y-1, y}, together with its coordinates.
// Optional feature macro: LINEBUF_ZERO_PAD_EN. When it is defined, rows 0..3
// are emitted and any tap that would lie above row 0 is forced to zero.
module smooth_col_feeder #(
    parameter logic [11:0] WIDTH  = 12'd640,
    parameter logic [11:0] HEIGHT = 12'd480
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_pixel,
    input  logic        i_valid,
    input  logic        i_sof,
    output logic [39:0] o_col,
    output logic        o_valid,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_frame_end,
    output logic        o_sync_err
);

    localparam int unsigned DEPTH = 32'(WIDTH);
    localparam int unsigned AW    = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

`ifdef LINEBUF_ZERO_PAD_EN
    // Zero every tap that refers to a row above row 0 of the frame.
    function automatic logic [39:0] pad_col(input logic [39:0] c, input logic [11:0] y);
        logic [39:0] r;
        r = c;
        if (y < 12'd4) begin
            case (y[1:0])
                2'd0:    r[39:8]  = 32'h0000_0000;
                2'd1:    r[39:16] = 24'h00_0000;
                2'd2:    r[39:24] = 16'h0000;
                2'd3:    r[39:32] = 8'h00;
                default: r = c;
            endcase
        end else begin
            r = c;
        end
        return r;
    endfunction
`endif

    // The four line memories are packed side by side in one word per column.
    // The word layout is {L4, L3, L2, L1}. A single read-then-shift write
    // therefore moves every row down by one line.
    logic [31:0] line_mem [0:DEPTH-1];

    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [39:0] col_q, col_d;
    logic [11:0] xo_q, xo_d;
    logic [11:0] yo_q, yo_d;
    logic        valid_q, valid_d;
    logic        fe_q, fe_d;
    logic        err_q, err_d;

    logic        resync_s;
    logic [11:0] x_eff_s;
    logic [11:0] y_eff_s;
    logic        last_x_s;
    logic        last_y_s;
    logic [AW-1:0] addr_s;
    logic [31:0] rd_word_s;
    logic [39:0] raw_col_s;

    // Effective position of the incoming pixel; an accepted sof snaps it to (0,0).
    always_comb begin
        resync_s  = i_valid & i_sof;
        x_eff_s   = resync_s ? 12'd0 : x_q;
        y_eff_s   = resync_s ? 12'd0 : y_q;
        last_x_s  = (x_eff_s == (WIDTH - 12'd1));
        last_y_s  = (y_eff_s == (HEIGHT - 12'd1));
        addr_s    = x_eff_s[AW-1:0];
        rd_word_s = line_mem[addr_s];
        raw_col_s = {rd_word_s, i_pixel};
    end

    // Next-state for the counters and the registered output stage.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        valid_d = 1'b0;
        fe_d    = 1'b0;
        err_d   = 1'b0;
        if (i_valid) begin
            xo_d  = x_eff_s;
            yo_d  = y_eff_s;
`ifdef LINEBUF_ZERO_PAD_EN
            col_d   = pad_col(raw_col_s, y_eff_s);
            valid_d = 1'b1;
`else
            col_d   = raw_col_s;
            valid_d = (y_eff_s >= 12'd4);
`endif
            fe_d  = last_x_s & last_y_s;
            err_d = i_sof & ((x_q != 12'd0) | (y_q != 12'd0));
            if (last_x_s) begin
                x_d = 12'd0;
                if (last_y_s) begin
                    y_d = 12'd0;
                end else begin
                    y_d = y_eff_s + 12'd1;
                end
            end else begin
                x_d = x_eff_s + 12'd1;
                y_d = y_eff_s;
            end
        end else begin
            valid_d = 1'b0;
            fe_d    = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Counter and output registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q     <= 12'd0;
            y_q     <= 12'd0;
            col_q   <= 40'd0;
            xo_q    <= 12'd0;
            yo_q    <= 12'd0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            err_q   <= err_d;
        end
    end

    // Line memory update. It is deliberately not reset, and the read above
    // returns old data. Rows shift down: L1 <= pixel, Lk+1 <= old Lk.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            line_mem[addr_s] <= {rd_word_s[23:0], i_pixel};
        end
    end

    assign o_col       = col_q;
    assign o_valid     = valid_q;
    assign o_x         = xo_q;
    assign o_y         = yo_q;
    assign o_frame_end = fe_q;
    assign o_sync_err  = err_q;

endmodule

// File: tb/tb_smooth_col_feeder.sv
// Self-checking bench for smooth_col_feeder (WIDTH=8, HEIGHT=6).
module tb_smooth_col_feeder;

    localparam int TW = 8;
    localparam int TH = 6;
`ifdef LINEBUF_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst_n;
    logic [7:0]  i_pixel;
    logic        i_valid;
    logic        i_sof;
    logic [39:0] o_col;
    logic        o_valid;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic        o_frame_end;
    logic        o_sync_err;

    smooth_col_feeder #(.WIDTH(12'd8), .HEIGHT(12'd6)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pixel(i_pixel), .i_valid(i_valid),
        .i_sof(i_sof), .o_col(o_col), .o_valid(o_valid), .o_x(o_x), .o_y(o_y),
        .o_frame_end(o_frame_end), .o_sync_err(o_sync_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-column history of the last four pixels written there,
    // plus the raster position.
    logic [7:0]  hist [TW][4];
    int          mx, my;
    logic [39:0] e_col;
    logic        e_valid, e_fe, e_err, col_known;
    logic [11:0] e_x, e_y;

    // Observation bookkeeping.
    int          nvalid, nerr, first_vx, first_vy;
    logic [39:0] cap_col [TH][TW];
    logic        cap_v   [TH][TW];
    logic        cap_fe  [TH][TW];

    typedef struct {
        int          x;
        int          y;
        logic [39:0] col;
        logic        fe;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0;
        e_col = 40'd0; e_valid = 1'b0; e_fe = 1'b0; e_err = 1'b0;
        e_x = 12'd0; e_y = 12'd0; col_known = 1'b1;
    endtask

    task automatic model_accept(input logic [7:0] pix, input logic sof);
        int ex, ey;
        logic [39:0] c;
        if (sof) begin
            ex = 0; ey = 0;
            e_err = (mx != 0) || (my != 0);
        end else begin
            ex = mx; ey = my;
            e_err = 1'b0;
        end
        c = {hist[ex][3], hist[ex][2], hist[ex][1], hist[ex][0], pix};
        if (ZP) begin
            for (int k = 1; k <= 4; k++) if (k > ey) c[8*k +: 8] = 8'h00;
        end
        e_valid   = ZP ? 1'b1 : (ey >= 4);
        e_col     = c;
        col_known = e_valid;
        e_x       = 12'(ex);
        e_y       = 12'(ey);
        e_fe      = (ex == TW - 1) && (ey == TH - 1);
        for (int k = 3; k > 0; k--) hist[ex][k] = hist[ex][k-1];
        hist[ex][0] = pix;
        if (ex + 1 == TW) begin
            mx = 0;
            my = (ey + 1 == TH) ? 0 : ey + 1;
        end else begin
            mx = ex + 1;
            my = ey;
        end
    endtask

    task automatic compare_all();
        chk("o_valid", {39'd0, o_valid}, {39'd0, e_valid});
        chk("o_x", {28'd0, o_x}, {28'd0, e_x});
        chk("o_y", {28'd0, o_y}, {28'd0, e_y});
        chk("o_frame_end", {39'd0, o_frame_end}, {39'd0, e_fe});
        chk("o_sync_err", {39'd0, o_sync_err}, {39'd0, e_err});
        if (col_known) chk("o_col", o_col, e_col);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic [7:0] pix, input logic v, input logic sof);
        i_pixel = pix; i_valid = v; i_sof = sof;
        @(posedge i_clk);
        if (v) begin
            model_accept(pix, sof);
        end else begin
            e_valid = 1'b0; e_fe = 1'b0; e_err = 1'b0;
        end
        @(negedge i_clk);
        compare_all();
        if (o_valid) begin
            if (nvalid == 0) begin first_vx = int'(o_x); first_vy = int'(o_y); end
            nvalid++;
            if (int'(o_x) < TW && int'(o_y) < TH) begin
                cap_col[o_y][o_x] = o_col;
                cap_v[o_y][o_x]   = 1'b1;
                cap_fe[o_y][o_x]  = o_frame_end;
            end
        end
        if (o_sync_err) nerr++;
    endtask

    task automatic clear_obs();
        nvalid = 0; nerr = 0; first_vx = -1; first_vy = -1;
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++) begin
                cap_v[y][x] = 1'b0; cap_col[y][x] = 40'd0; cap_fe[y][x] = 1'b0;
            end
    endtask

    task automatic send_frame(input bit gap, input bit sof_first);
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++) begin
                step(8'(16*y + x), 1'b1, sof_first && x == 0 && y == 0);
                if (gap) step(8'h00, 1'b0, 1'b0);
            end
        step(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        for (int x = 0; x < TW; x++)
            for (int k = 0; k < 4; k++) hist[x][k] = 8'h00;
        model_reset();
        clear_obs();
        i_rst_n = 1'b0; i_pixel = 8'h00; i_valid = 1'b0; i_sof = 1'b0;
        repeat (3) @(negedge i_clk);
        compare_all();
        i_rst_n = 1'b1;

        // Full frame, continuous input, then table-driven spot checks.
        clear_obs();
        send_frame(1'b0, 1'b1);
        if (ZP) begin
            vecs.push_back('{0, 0, 40'h0000000000, 1'b0});
            vecs.push_back('{2, 1, 40'h0000000212, 1'b0});
            vecs.push_back('{0, 4, 40'h0010203040, 1'b0});
            vecs.push_back('{7, 5, 40'h1727374757, 1'b1});
        end else begin
            vecs.push_back('{0, 4, 40'h0010203040, 1'b0});
            vecs.push_back('{3, 4, 40'h0313233343, 1'b0});
            vecs.push_back('{7, 5, 40'h1727374757, 1'b1});
        end
        for (int i = 0; i < vecs.size(); i++) begin
            chk("tbl_valid", {39'd0, cap_v[vecs[i].y][vecs[i].x]}, 40'd1);
            chk("tbl_col", cap_col[vecs[i].y][vecs[i].x], vecs[i].col);
            chk("tbl_fe", {39'd0, cap_fe[vecs[i].y][vecs[i].x]}, {39'd0, vecs[i].fe});
        end
        chk("frame_count", 40'(nvalid), ZP ? 40'd48 : 40'd16);
        chk("first_valid_y", 40'(first_vy), ZP ? 40'd0 : 40'd4);

        // Gapped input: alternate valid/idle cycles.
        clear_obs();
        send_frame(1'b1, 1'b1);
        chk("gap_count", 40'(nvalid), ZP ? 40'd48 : 40'd16);
        chk("gap_col_74", cap_col[4][7], 40'h0717273747);

        // Stray sof at (5,2).
        clear_obs();
        for (int p = 0; p < 2*TW + 5; p++) step(8'(16*(p/TW) + p%TW), 1'b1, p == 0);
        step(8'h25, 1'b1, 1'b1);
        chk("stray_err", {39'd0, o_sync_err}, 40'd1);
        chk("stray_x", {28'd0, o_x}, 40'd0);
        chk("stray_y", {28'd0, o_y}, 40'd0);
        step(8'h26, 1'b1, 1'b0);
        chk("stray_next_x", {28'd0, o_x}, 40'd1);
        chk("stray_next_y", {28'd0, o_y}, 40'd0);
        chk("stray_err_once", 40'(nerr), 40'd1);

        // Reset asserted mid-frame at (4,3).
        send_frame(1'b0, 1'b1);
        for (int p = 0; p < 3*TW + 4; p++) step(8'(16*(p/TW) + p%TW), 1'b1, p == 0);
        i_valid = 1'b0; i_sof = 1'b0;
        #2 i_rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        @(negedge i_clk);
        compare_all();
        i_rst_n = 1'b1;
        clear_obs();
        send_frame(1'b0, 1'b0);
        chk("post_rst_first_x", 40'(first_vx), 40'd0);
        chk("post_rst_first_y", 40'(first_vy), ZP ? 40'd0 : 40'd4);
        chk("post_rst_no_err", 40'(nerr), 40'd0);

        // sof on the last pixel of a frame.
        for (int p = 0; p < TW*TH - 1; p++) step(8'(16*(p/TW) + p%TW), 1'b1, p == 0);
        step(8'h57, 1'b1, 1'b1);
        chk("last_sof_err", {39'd0, o_sync_err}, 40'd1);
        chk("last_sof_fe", {39'd0, o_frame_end}, 40'd0);
        chk("last_sof_x", {28'd0, o_x}, 40'd0);
        chk("last_sof_y", {28'd0, o_y}, 40'd0);

        // Randomized traffic with occasional stray sof.
        for (int n = 0; n < 2000; n++) begin
            logic v;
            v = ($urandom_range(3) != 0);
            step(8'($urandom), v, v && ($urandom_range(80) == 0));
        end
        step(8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
